// File: rtl/adc_emu_pkg.sv
// adc_emu_pkg: shared FSM states, event mode codes and LFSR constants for the ADC emulator
package adc_emu_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LFILL, ST_EVENT, ST_TFILL} state_e;
    typedef enum logic [1:0] {MODE_RAMP, MODE_CONST, MODE_PRBS, MODE_RSVD} mode_e;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // feedback taps at bit positions 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/adc_emu_if.sv
// adc_emu_if: configuration inputs and sample outputs of the ADC emulator
interface adc_emu_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10
);
    logic              enable;
    logic              trigger;
    logic              single_shot;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  lfill_len;
    logic [CNT_W-1:0]  event_len;
    logic [CNT_W-1:0]  tfill_len;
    logic [DATA_W-1:0] baseline;
    logic [DATA_W-1:0] amplitude;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              event_flag;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    modport master (
        input  enable, trigger, single_shot, mode, lfill_len, event_len, tfill_len, baseline, amplitude,
        output data, data_valid, event_flag, busy, frame_done, frame_cnt
    );
    modport slave (
        output enable, trigger, single_shot, mode, lfill_len, event_len, tfill_len, baseline, amplitude,
        input  data, data_valid, event_flag, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/adc_emu_lfsr.sv
// adc_emu_lfsr: 16-bit Fibonacci LFSR that steps only when advance is high
module adc_emu_lfsr
    import adc_emu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    output logic [15:0] value
);
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = advance ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lfsr_q <= LFSR_SEED;
        else        lfsr_q <= lfsr_d;
    assign value = lfsr_q;
endmodule

// File: rtl/adc_emu_gen.sv
// adc_emu_gen: framed ADC sample emulator (leading fill, event, trailing fill) with ramp,
// constant and pseudo-random event shapes; samples are registered one cycle behind the FSM.
module adc_emu_gen
    import adc_emu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    adc_emu_if.master bus
);
    state_e            state_q, state_d, phase;
    mode_e             mode_q, mode_d;
    logic              ss_q, ss_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, lf_q, lf_d, ev_q, ev_d, tf_q, tf_d, len;
    logic [DATA_W-1:0] base_q, base_d, amp_q, amp_d, data_q, data_d, rnd, ev_data;
    logic              valid_q, valid_d, evf_q, evf_d, done_q, done_d;
    logic [15:0]       fcnt_q, fcnt_d, lfsr;
    logic              fin, last, end_frame, adv, latch;

    adc_emu_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .advance(adv), .value(lfsr));

    always_comb begin
        // empty phases are folded away so the frame never spends a cycle in them
        phase = state_q;
        if (phase == ST_LFILL && lf_q == '0) phase = ST_EVENT;
        if (phase == ST_EVENT && ev_q == '0) phase = ST_TFILL;
        len = phase == ST_LFILL ? lf_q : phase == ST_EVENT ? ev_q : tf_q;
        fin = phase == ST_TFILL && tf_q == '0;
        last = fin || cnt_q == len - 1'b1;
        end_frame = last && (phase == ST_TFILL || (phase == ST_EVENT && tf_q == '0) || (ev_q == '0 && tf_q == '0));
        rnd = DATA_W'(lfsr);
        ev_data = mode_q == MODE_RAMP ? base_q + DATA_W'(cnt_q + 1'b1)
                : mode_q == MODE_PRBS ? base_q + (rnd & amp_q) : base_q + amp_q;
        state_d = state_q;
        cnt_d = cnt_q;
        mode_d = mode_q;
        ss_d = ss_q;
        lf_d = lf_q;
        ev_d = ev_q;
        tf_d = tf_q;
        base_d = base_q;
        amp_d = amp_q;
        data_d = base_q;
        valid_d = 1'b0;
        evf_d = 1'b0;
        done_d = 1'b0;
        fcnt_d = fcnt_q;
        adv = 1'b0;
        latch = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.enable && bus.trigger) begin
                latch = 1'b1;
                state_d = ST_LFILL;
                cnt_d = '0;
            end
        end else if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d = '0;
        end else begin
            valid_d = !fin;
            evf_d = phase == ST_EVENT;
            data_d = phase == ST_EVENT ? ev_data : base_q;
            adv = phase == ST_EVENT && mode_q == MODE_PRBS;
            cnt_d = last ? '0 : cnt_q + 1'b1;
            state_d = !last ? phase : phase == ST_LFILL ? ST_EVENT : ST_TFILL;
            if (end_frame) begin
                done_d = 1'b1;
                fcnt_d = fcnt_q + 1'b1;
                latch = !ss_q;
                state_d = ss_q ? ST_IDLE : ST_LFILL;
            end
        end
        if (latch) begin
            mode_d = mode_e'(bus.mode);
            ss_d = bus.single_shot;
            lf_d = bus.lfill_len;
            ev_d = bus.event_len;
            tf_d = bus.tfill_len;
            base_d = bus.baseline;
            amp_d = bus.amplitude;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q <= '0;
            mode_q <= MODE_RAMP;
            ss_q <= 1'b0;
            lf_q <= '0;
            ev_q <= '0;
            tf_q <= '0;
            base_q <= '0;
            amp_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
            evf_q <= 1'b0;
            done_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            ss_q <= ss_d;
            lf_q <= lf_d;
            ev_q <= ev_d;
            tf_q <= tf_d;
            base_q <= base_d;
            amp_q <= amp_d;
            data_q <= data_d;
            valid_q <= valid_d;
            evf_q <= evf_d;
            done_q <= done_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign bus.data = data_q;
    assign bus.data_valid = valid_q;
    assign bus.event_flag = evf_q;
    assign bus.frame_done = done_q;
    assign bus.frame_cnt = fcnt_q;
    assign bus.busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_adc_emu_gen.sv
// tb_adc_emu_gen: directed self-checking bench for adc_emu_gen; inputs driven and outputs
// sampled on the falling clock edge.
module tb_adc_emu_gen;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    logic [15:0] lfsr_m = 16'hACE1;
    logic [7:0] e3 [6] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'hFE};

    always #5 clk = ~clk;

    adc_emu_if #(.DATA_W(8), .CNT_W(10)) bus ();
    adc_emu_gen #(.DATA_W(8), .CNT_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [15:0] lf_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input string tag, input logic v, input logic [7:0] d, input logic e, input logic f);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(bus.data_valid), 32'(v));
        chk({tag, ".data"}, 32'(bus.data), 32'(d));
        chk({tag, ".event"}, 32'(bus.event_flag), 32'(e));
        chk({tag, ".done"}, 32'(bus.frame_done), 32'(f));
    endtask

    task automatic cfg(input logic ss, input logic [1:0] m, input int lf, input int ev, input int tf,
                       input logic [7:0] b, input logic [7:0] a);
        bus.single_shot = ss;
        bus.mode = m;
        bus.lfill_len = 10'(lf);
        bus.event_len = 10'(ev);
        bus.tfill_len = 10'(tf);
        bus.baseline = b;
        bus.amplitude = a;
    endtask

    task automatic start(input string tag);
        bus.trigger = 1'b1;
        @(negedge clk);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".latency"}, 32'(bus.data_valid), 32'd0);
        bus.trigger = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.trigger = 1'b0;
        cfg(1'b1, 2'd0, 10, 7, 10, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst.data", 32'(bus.data), 32'd0);
        chk("rst.valid", 32'(bus.data_valid), 32'd0);
        chk("rst.event", 32'(bus.event_flag), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.frame_done), 32'd0);
        chk("rst.cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        bus.enable = 1'b1;
        // default 10/7/10 ramp frame
        start("t1");
        for (int j = 0; j < 27; j++)
            sample("t1", 1'b1, (j >= 10 && j < 17) ? 8'(j - 9) : 8'h00, j >= 10 && j < 17, j == 26);
        chk("t1.cnt", 32'(bus.frame_cnt), 32'd1);
        chk("t1.busy", 32'(bus.busy), 32'd0);
        sample("t1.after", 1'b0, 8'h00, 1'b0, 1'b0);
        // free-run constant 2/3/2, three frames then stop
        cfg(1'b0, 2'd1, 2, 3, 2, 8'h10, 8'h20);
        start("t2");
        for (int j = 0; j < 21; j++)
            sample("t2", 1'b1, ((j % 7) >= 2 && (j % 7) < 5) ? 8'h30 : 8'h10,
                   (j % 7) >= 2 && (j % 7) < 5, (j % 7) == 6);
        chk("t2.cnt", 32'(bus.frame_cnt), 32'd4);
        bus.enable = 1'b0;
        sample("t2.stop", 1'b0, 8'h10, 1'b0, 1'b0);
        chk("t2.stop.busy", 32'(bus.busy), 32'd0);
        chk("t2.stop.cnt", 32'(bus.frame_cnt), 32'd4);
        bus.enable = 1'b1;
        // ramp wrap; baseline change mid-frame must be ignored
        cfg(1'b1, 2'd0, 1, 4, 1, 8'hFE, 8'h00);
        start("t3");
        bus.baseline = 8'h55;
        for (int j = 0; j < 6; j++)
            sample("t3", 1'b1, e3[j], j >= 1 && j <= 4, j == 5);
        chk("t3.cnt", 32'(bus.frame_cnt), 32'd5);
        // zero-length fills
        cfg(1'b1, 2'd0, 0, 3, 0, 8'h00, 8'h00);
        start("t4");
        for (int j = 0; j < 3; j++)
            sample("t4", 1'b1, 8'(j + 1), 1'b1, j == 2);
        sample("t4.after", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4.cnt", 32'(bus.frame_cnt), 32'd6);
        // all phases empty
        cfg(1'b1, 2'd0, 0, 0, 0, 8'h00, 8'h00);
        start("t4z");
        sample("t4z", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4z.cnt", 32'(bus.frame_cnt), 32'd7);
        chk("t4z.busy", 32'(bus.busy), 32'd0);
        sample("t4z.after", 1'b0, 8'h00, 1'b0, 1'b0);
        // enable dropped on 5th event sample
        cfg(1'b1, 2'd0, 2, 8, 2, 8'h00, 8'h00);
        start("t5");
        for (int j = 0; j < 7; j++)
            sample("t5", 1'b1, j < 2 ? 8'h00 : 8'(j - 1), j >= 2, 1'b0);
        bus.enable = 1'b0;
        sample("t5.abort", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("t5.busy", 32'(bus.busy), 32'd0);
        chk("t5.cnt", 32'(bus.frame_cnt), 32'd7);
        bus.enable = 1'b1;
        // asynchronous reset mid-frame
        cfg(1'b1, 2'd1, 3, 3, 3, 8'h33, 8'h11);
        start("t6");
        for (int j = 0; j < 4; j++)
            sample("t6", 1'b1, j < 3 ? 8'h33 : 8'h44, j == 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.data", 32'(bus.data), 32'd0);
        chk("t6.rst.valid", 32'(bus.data_valid), 32'd0);
        chk("t6.rst.event", 32'(bus.event_flag), 32'd0);
        chk("t6.rst.busy", 32'(bus.busy), 32'd0);
        chk("t6.rst.done", 32'(bus.frame_done), 32'd0);
        chk("t6.rst.cnt", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6.idle.busy", 32'(bus.busy), 32'd0);
        chk("t6.idle.valid", 32'(bus.data_valid), 32'd0);
        // pseudo-random event, two frames continuing one sequence
        cfg(1'b1, 2'd2, 1, 3, 1, 8'h00, 8'hFF);
        start("t7a");
        sample("t7a.lf", 1'b1, 8'h00, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            sample("t7a.ev", 1'b1, lfsr_m[7:0] & 8'hFF, 1'b1, 1'b0);
            lfsr_m = lf_step(lfsr_m);
        end
        sample("t7a.tf", 1'b1, 8'h00, 1'b0, 1'b1);
        chk("t7a.cnt", 32'(bus.frame_cnt), 32'd1);
        cfg(1'b1, 2'd2, 1, 3, 1, 8'h10, 8'h0F);
        start("t7b");
        sample("t7b.lf", 1'b1, 8'h10, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            sample("t7b.ev", 1'b1, 8'h10 + (lfsr_m[7:0] & 8'h0F), 1'b1, 1'b0);
            lfsr_m = lf_step(lfsr_m);
        end
        sample("t7b.tf", 1'b1, 8'h10, 1'b0, 1'b1);
        chk("t7b.cnt", 32'(bus.frame_cnt), 32'd2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_emu_gen.md
ADC_EMU_GEN -- requirements
Module: adc_emu_gen

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter CNT_W, default 10, width of phase-length inputs and internal phase counter.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  generator enable; low aborts activity.
REQ-006 trigger  input  1  frame start request, level-sampled in IDLE.
REQ-007 single_shot  input  1  1: one frame per trigger; 0: free-run back-to-back frames.
REQ-008 mode  input  2  event shape: 0 ramp, 1 constant, 2 pseudo-random, 3 treated as constant.
REQ-009 lfill_len / event_len / tfill_len  input  CNT_W each  leading-fill, event and trailing-fill lengths in samples.
REQ-010 baseline  input  DATA_W  fill level and event offset.
REQ-011 amplitude  input  DATA_W  constant-mode level; pseudo-random mask.
REQ-012 data  output  DATA_W  registered sample.
REQ-013 data_valid  output  1  data holds a frame sample.
REQ-014 event_flag  output  1  current sample belongs to the event phase.
REQ-015 busy  output  1  FSM not in IDLE.
REQ-016 frame_done  output  1  one-cycle pulse with the last sample of each frame.
REQ-017 frame_cnt  output  16  completed frames, wraps 0xFFFF->0.

Function
REQ-018 FSM states IDLE, LFILL, EVENT, TFILL; transitions IDLE->LFILL->EVENT->TFILL, each phase lasting its length in cycles.
REQ-019 Zero-length phase skipped in the same cycle; all three zero: frame completes in one cycle, no valid sample, frame_done and frame_cnt still update.
REQ-020 IDLE exit when enable=1 and trigger=1 sampled at edge k; first sample presented (data_valid=1) after edge k+1; latency fixed at one cycle.
REQ-021 All config inputs (mode, lengths, baseline, amplitude, single_shot) latched on IDLE exit and on each free-run frame restart; mid-frame changes ignored.
REQ-022 Fill samples: data=baseline, event_flag=0.
REQ-023 Ramp event sample i (0-based): data=(baseline+i+1) mod 2^DATA_W.
REQ-024 Constant event: data=(baseline+amplitude) mod 2^DATA_W.
REQ-025 Pseudo-random event: data=(baseline+(lfsr[DATA_W-1:0] & amplitude)) mod 2^DATA_W; 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 0xACE1; advances only on pseudo-random event samples; DATA_W>16 zero-extends lfsr.
REQ-026 End of TFILL: single_shot=1 -> IDLE; single_shot=0 and enable=1 -> LFILL with no gap cycle (free-run period = lfill+event+tfill).
REQ-027 trigger while busy ignored; held trigger in single-shot starts a new frame immediately after IDLE is reached (one IDLE cycle between frames).
REQ-028 enable low in any non-IDLE state: next edge state=IDLE, data_valid=0, data=baseline latched value, no frame_done, frame_cnt unchanged.
REQ-029 Outside frames: data_valid=0, event_flag=0, data holds last latched baseline.

Reset
REQ-030 rst_n low: state IDLE, data=0, data_valid=0, event_flag=0, busy=0, frame_done=0, frame_cnt=0, lfsr=0xACE1, latched config=0.
REQ-031 Reset mid-frame takes effect immediately (asynchronous); release requires a fresh trigger.

Structure
REQ-032 Package adc_emu_pkg holds state enumeration, mode codes, LFSR seed and tap constants.
REQ-033 Sub-module adc_emu_lfsr (16-bit LFSR, advance input, async active-low reset) instantiated once.

Verification
REQ-034 Defaults (10/7/10), ramp, baseline 0, single_shot=1, trigger pulse -> 10×0, 1..7, 10×0, frame_done on 27th sample, frame_cnt=1, busy=0 after.
REQ-035 Free-run, lengths 2/3/2, constant, baseline 0x10, amplitude 0x20 -> repeating 0x10,0x10,0x30,0x30,0x30,0x10,0x10 period 7, frame_done every 7 cycles.
REQ-036 Ramp, baseline 0xFE, event_len 4 -> event data 0xFF,0x00,0x01,0x02 (wrap).
REQ-037 Lengths 0/3/0 ramp baseline 0 -> exactly 1,2,3 valid, event_flag on all three; lengths 0/0/0 -> frame_done pulse, no valid sample.
REQ-038 enable dropped on 5th event sample -> next cycle data_valid=0, IDLE, frame_cnt unchanged; rst_n pulse mid-frame -> all outputs reset values immediately.
REQ-039 Pseudo-random, baseline 0, amplitude 0xFF, event_len 3 -> data equals bench LFSR model from seed 0xACE1; second frame continues sequence, not reseeded.
